// File: rtl/adc_spi_responder.sv
// SPI slave emulating an MCP3002-style two-channel serial ADC.
// All pins are oversampled in the sysclk domain; SCK only produces edge strobes.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 10
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              adc_cs,
  input  logic              adc_sck,
  input  logic              sdata_to_adc,
  output logic              sdata_from_adc,
  output logic              sdo_en,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  output logic [DATA_W-1:0] sampled_value,
  output logic [2:0]        sampled_cfg,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int CW = (DATA_W > 4) ? $clog2(DATA_W) : 2;
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_CFG,
    S_NULL,
    S_DATA_MSB,
    S_DATA_LSB,
    S_DONE
  } state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sck_prev_q, sck_prev_d;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             cfg_q, cfg_d;
  logic                   sdo_q, sdo_d;
  logic                   sdo_en_q, sdo_en_d;
  logic [DATA_W-1:0]      value_q, value_d;
  logic [2:0]             scfg_q, scfg_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   cs_s, sck_s, sdi_s;
  logic                   cs_fall, sck_rise, sck_fall;
  logic [DATA_W-1:0]      result;

  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  assign cs_fall  = cs_prev_q & ~cs_s;
  // SCK strobes are gated by CS so a CS rise coinciding with an edge wins
  assign sck_rise = ~cs_s & ~sck_prev_q &  sck_s;
  assign sck_fall = ~cs_s &  sck_prev_q & ~sck_s;

  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0],  adc_cs};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], adc_sck};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdata_to_adc};
    cs_prev_d  = cs_s;
    sck_prev_d = sck_s;
  end

  // Differential modes saturate at zero instead of wrapping
  always_comb begin
    result = '0;
    unique case (cfg_q[2:1])
      2'b10: result = ch0_data;
      2'b11: result = ch1_data;
      2'b00: if (ch0_data >= ch1_data) result = ch0_data - ch1_data;
      2'b01: if (ch1_data >= ch0_data) result = ch1_data - ch0_data;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cfg_d    = cfg_q;
    sdo_d    = sdo_q;
    sdo_en_d = sdo_en_q;
    value_d  = value_q;
    scfg_d   = scfg_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (state_q != S_IDLE && cs_s) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      sdo_d    = 1'b0;
      sdo_en_d = 1'b0;
      done_d   = (state_q == S_DONE);
      // a select with no start bit is just an idle select, not an error
      err_d    = (state_q != S_DONE) && (state_q != S_WAIT_START);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d  = S_WAIT_START;
            cnt_d    = '0;
            sdo_d    = 1'b0;
            sdo_en_d = 1'b1;
          end
        end
        S_WAIT_START: begin
          if (sck_rise && sdi_s) begin
            state_d = S_CFG;
            cnt_d   = '0;
          end
        end
        S_CFG: begin
          if (sck_rise) begin
            cfg_d = {cfg_q[1:0], sdi_s};
            if (cnt_q == CW'(2)) begin
              state_d = S_NULL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_NULL: begin
          if (sck_fall) begin
            value_d = result;
            scfg_d  = cfg_q;
            sdo_d   = 1'b0;
            cnt_d   = CNT_MAX;
            state_d = S_DATA_MSB;
          end
        end
        S_DATA_MSB: begin
          if (sck_fall) begin
            sdo_d = value_q[cnt_q];
            if (cnt_q == '0) begin
              if (scfg_q[0]) begin
                state_d = S_DONE;
              end else begin
                state_d = S_DATA_LSB;
                cnt_d   = CW'(1);
              end
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        S_DATA_LSB: begin
          // B0 was already sent at the end of the MSB-first half
          if (sck_fall) begin
            sdo_d = value_q[cnt_q];
            if (cnt_q == CNT_MAX) state_d = S_DONE;
            else                  cnt_d   = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (sck_fall) sdo_d = 1'b0;
        end
        default: begin
          state_d  = S_IDLE;
          sdo_d    = 1'b0;
          sdo_en_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cfg_q      <= '0;
      sdo_q      <= 1'b0;
      sdo_en_q   <= 1'b0;
      value_q    <= '0;
      scfg_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cs_sync_q  <= cs_sync_d;
      sck_sync_q <= sck_sync_d;
      sdi_sync_q <= sdi_sync_d;
      cs_prev_q  <= cs_prev_d;
      sck_prev_q <= sck_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      sdo_q      <= sdo_d;
      sdo_en_q   <= sdo_en_d;
      value_q    <= value_d;
      scfg_q     <= scfg_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sdata_from_adc = sdo_q;
  assign sdo_en         = sdo_en_q;
  assign sampled_value  = value_q;
  assign sampled_cfg    = scfg_q;
  assign frame_done     = done_q;
  assign frame_err      = err_q;

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable SPI slave that emulates the two-channel 10-bit serial ADC (MCP3002 protocol) at the far end of spi2adc.
- Decodes the start/config bits arriving on SDI and returns a 10-bit sample on SDO, taken from parallel inputs.
- Serves two purposes: a loopback target in hardware-in-the-loop builds, and the reference responder in spi2adc regression benches.
- All pin inputs are oversampled in the sysclk domain; no logic is clocked by the SPI clock.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on adc_cs, adc_sck and sdata_to_adc (minimum 2).
- DATA_W, 10, sample width; the bit counter and shift register sizes follow from it.

Ports:
- sysclk  input  1  system clock (50 MHz); must be at least 8x adc_sck.
- rst_n  input  1  asynchronous active-low reset.
- adc_cs  input  1  chip select from master, low active.
- adc_sck  input  1  SPI clock from master; idles low (mode 0).
- sdata_to_adc  input  1  config bits from master (SDI).
- sdata_from_adc  output  1  serial result to master (SDO).
- sdo_en  output  1  1 while SDO is driven; top level tri-states SDO when this is 0.
- ch0_data  input  DATA_W  CH0 analogue value (unsigned).
- ch1_data  input  DATA_W  CH1 analogue value (unsigned).
- sampled_value  output  DATA_W  last latched conversion result.
- sampled_cfg  output  3  {SGL, ODD, MSBF} of the last decoded frame.
- frame_done  output  1  one-cycle pulse: complete frame ended by CS rising.
- frame_err  output  1  one-cycle pulse: CS rose before the last data bit.

Behaviour:
- Reset (async, rst_n=0): state IDLE; sdata_from_adc=0; sdo_en=0; sampled_value=0; sampled_cfg=0; frame_done=0; frame_err=0; bit counter=0; synchronizers cleared to cs=1, sck=0, sdi=0.
- Edge detection: rise/fall strobes come from the last two synchronized samples of adc_sck. A strobe is valid only when synchronized CS is low.
- Latency: SDO changes exactly SYNC_STAGES+1 sysclk cycles after the adc_sck falling pin edge.
- IDLE:
  - Synchronized CS falls -> WAIT_START; sdo_en=1; SDO=0.
- WAIT_START:
  - Each SCK rise samples SDI.
  - Leading 0s are ignored.
  - First 1 -> CFG, counter=0.
- CFG:
  - Three SCK rises capture SGL, ODD, MSBF in that order.
  - After the third -> NULL.
- NULL:
  - Next SCK fall: latch the result into sampled_value and sampled_cfg; drive SDO=0 (null bit); counter=DATA_W-1 -> DATA_MSB.
- Result selection:
  - SGL=1, ODD=0 -> ch0_data.
  - SGL=1, ODD=1 -> ch1_data.
  - SGL=0, ODD=0 -> ch0-ch1 if ch0>=ch1, else 0.
  - SGL=0, ODD=1 -> ch1-ch0 if ch1>=ch0, else 0.
  - Subtraction is unsigned, DATA_W wide, and saturates at 0 (no wrap).
- DATA_MSB:
  - Each SCK fall drives the bit at position counter, then decrements the counter.
  - After bit 0 is driven: if MSBF=1 -> DONE; if MSBF=0 -> DATA_LSB with counter=1.
- DATA_LSB:
  - Each SCK fall drives bit 1, 2, ... DATA_W-1 in turn (B0 is shared, not repeated).
  - After bit DATA_W-1 -> DONE.
- DONE:
  - Further SCK falls drive SDO=0; this is not an error.
- CS rising, any state other than IDLE:
  - Go to IDLE next cycle; sdo_en=0; SDO=0.
  - One-cycle pulse: frame_done if the state was DONE, otherwise frame_err.
  - No pulse from WAIT_START with no start bit seen (aborted idle select).
- CS rising on the same sysclk cycle as an SCK edge: CS wins; the edge is ignored.
- sampled_value is held across frames; an aborted frame after NULL keeps its new latched value.
- ch0_data and ch1_data are read only on the latch cycle; later changes do not affect the frame in flight.
- rst_n asserted mid-frame: immediate IDLE, no pulse generated.

Test Plan:
1. ch0=10'h2A5, SDI start=1, SGL=1, ODD=0, MSBF=1, 16 SCK at 1 MHz -> SDO after config reads 0 then 1010100101; frame_done one pulse; sampled_value=10'h2A5; sampled_cfg=3'b101.
2. ch1=10'h001, config 1,1,0, 24 SCK -> SDO shows null, 0000000001, then 000000000 (LSB-first B1..B9), then zeros; frame_done pulse.
3. Differential: ch0=100, ch1=300, config 0,0,1 -> result 0. Same inputs with config 0,1,1 -> result 200 (10'h0C8).
4. Three leading 0s before the start bit -> identical result to scenario 1, shifted by 3 clocks.
5. CS raised after B5 -> frame_err one pulse; no frame_done; sdo_en=0 within SYNC_STAGES+1 cycles; the next frame decodes correctly.
6. rst_n pulsed low mid-DATA_MSB -> all outputs at reset values immediately, no pulses; next frame after release is correct. Also check that sdo_en stays 0 whenever CS is high.
